// File: rtl/pong_pkg.sv
// Shared pong definitions: score FSM states, serve encodings and 7-segment masks.
package pong_pkg;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    localparam logic [1:0] SERVE_LEFT  = 2'b10;
    localparam logic [1:0] SERVE_RIGHT = 2'b01;

    // Segment masks for digits 0..9, bit order {a,b,c,d,e,f,g}.
    localparam logic [6:0] SEG_MASK [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    // Codes above 9 render as an empty digit.
    function automatic logic [6:0] seg_mask(input logic [3:0] d);
        if (d > 4'd9) return 7'd0;
        return SEG_MASK[d];
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational hit test of one pixel against a 7-segment digit drawn in a box.
module seg7_digit
    import pong_pkg::*;
#(
    parameter int DIGIT_SEG_LEN = 16,
    parameter int DIGIT_SEG_W   = 4
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] ox,
    input  logic [9:0] oy,
    input  logic [3:0] digit,
    input  logic       blank,
    output logic       lit
);
    localparam logic [10:0] L    = 11'(DIGIT_SEG_LEN);
    localparam logic [10:0] L2   = 11'(2 * DIGIT_SEG_LEN);
    localparam logic [10:0] W    = 11'(DIGIT_SEG_W);
    localparam logic [10:0] HW   = 11'(DIGIT_SEG_W / 2);

    logic [10:0] dx, dy;
    logic        in_box, top, bot;
    logic [6:0]  segs;

    // 11-bit subtraction: a pixel left of/above the origin sets bit 10 and misses.
    assign dx = {1'b0, x} - {1'b0, ox};
    assign dy = {1'b0, y} - {1'b0, oy};

    assign in_box = !dx[10] && (dx < L) && !dy[10] && (dy < L2);
    assign top    = dy < L;
    assign bot    = !top;

    // Segment geometry in box-relative coordinates, ordered {a,b,c,d,e,f,g}.
    always_comb begin
        segs    = '0;
        segs[6] = dy < W;
        segs[5] = (dx >= L - W) && top;
        segs[4] = (dx >= L - W) && bot;
        segs[3] = dy >= L2 - W;
        segs[2] = (dx < W) && bot;
        segs[1] = (dx < W) && top;
        segs[0] = (dy >= L - HW) && (dy < L + HW);
    end

    assign lit = in_box && !blank && |(segs & seg_mask(digit));

endmodule

// File: rtl/score_keeper.sv
// Per-player point counting, game-over/serve decisions and score digit rendering.
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int P1_DIGIT_X   = 280,
    parameter int P2_DIGIT_X   = 344,
    parameter int DIGIT_Y      = 16,
    parameter int SEG_LEN      = 16,
    parameter int SEG_W        = 4,
    parameter int FLASH_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       de,
    input  logic       frame,
    input  logic       p1_point,
    input  logic       p2_point,
    input  logic       new_game,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] serve_side,
    output logic       game_over,
    output logic       winner,
    output logic       pix_en
);
    localparam int              FW         = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [3:0]      WIN        = 4'(WIN_SCORE);
    localparam logic [FW-1:0]   FLASH_LAST = FW'(FLASH_FRAMES - 1);

    state_t        state, state_n;
    logic [3:0]    p1_n, p2_n;
    logic [1:0]    serve_n;
    logic          win_n;
    logic          p1_pend, p2_pend, p1_pend_n, p2_pend_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          phase_on, phase_n;
    logic          hit_p1, hit_p2, blank_p1, blank_p2;

    assign game_over = (state == ST_OVER);

    // State register for FSM, scores, pending flags, flash timer and pixel output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_PLAY;
            p1_score   <= '0;
            p2_score   <= '0;
            serve_side <= SERVE_RIGHT;
            winner     <= 1'b0;
            p1_pend    <= 1'b0;
            p2_pend    <= 1'b0;
            fcnt       <= '0;
            phase_on   <= 1'b1;
            pix_en     <= 1'b0;
        end else begin
            state      <= state_n;
            p1_score   <= p1_n;
            p2_score   <= p2_n;
            serve_side <= serve_n;
            winner     <= win_n;
            p1_pend    <= p1_pend_n;
            p2_pend    <= p2_pend_n;
            fcnt       <= fcnt_n;
            phase_on   <= phase_n;
            pix_en     <= de & (hit_p1 | hit_p2);
        end
    end

    // Next-state logic: scores only move on the frame strobe so the digits never tear.
    always_comb begin
        state_n   = state;
        p1_n      = p1_score;
        p2_n      = p2_score;
        serve_n   = serve_side;
        win_n     = winner;
        p1_pend_n = p1_pend | p1_point;
        p2_pend_n = p2_pend | p2_point;
        fcnt_n    = fcnt;
        phase_n   = phase_on;
        case (state)
            ST_PLAY: begin
                if (frame) begin
                    // Pulses coincident with the strobe belong to the next frame.
                    p1_pend_n = p1_point;
                    p2_pend_n = p2_point;
                    if (p1_pend && p1_score != WIN) p1_n = 4'(p1_score + 4'd1);
                    if (p2_pend && p2_score != WIN) p2_n = 4'(p2_score + 4'd1);
                    // Loser serves; a double point hands the serve to p1.
                    if (p1_pend) serve_n = SERVE_RIGHT;
                    if (p2_pend) serve_n = SERVE_LEFT;
                    if (p1_n == WIN) begin
                        state_n = ST_OVER;
                        win_n   = 1'b0;
                    end else if (p2_n == WIN) begin
                        state_n = ST_OVER;
                        win_n   = 1'b1;
                    end
                    if (state_n == ST_OVER) begin
                        p1_pend_n = 1'b0;
                        p2_pend_n = 1'b0;
                    end
                end
            end
            ST_OVER: begin
                p1_pend_n = 1'b0;
                p2_pend_n = 1'b0;
                if (frame) begin
                    if (new_game) begin
                        state_n = ST_PLAY;
                        p1_n    = '0;
                        p2_n    = '0;
                        serve_n = winner ? SERVE_LEFT : SERVE_RIGHT;
                        fcnt_n  = '0;
                        phase_n = 1'b1;
                    end else if (fcnt == FLASH_LAST) begin
                        fcnt_n  = '0;
                        phase_n = !phase_on;
                    end else begin
                        fcnt_n  = fcnt + 1'b1;
                    end
                end
            end
            default: state_n = ST_PLAY;
        endcase
    end

    assign blank_p1 = game_over && !phase_on && !winner;
    assign blank_p2 = game_over && !phase_on &&  winner;

    seg7_digit #(.DIGIT_SEG_LEN(SEG_LEN), .DIGIT_SEG_W(SEG_W)) u_dig_p1 (
        .x(x), .y(y), .ox(10'(P1_DIGIT_X)), .oy(10'(DIGIT_Y)),
        .digit(p1_score), .blank(blank_p1), .lit(hit_p1)
    );

    seg7_digit #(.DIGIT_SEG_LEN(SEG_LEN), .DIGIT_SEG_W(SEG_W)) u_dig_p2 (
        .x(x), .y(y), .ox(10'(P2_DIGIT_X)), .oy(10'(DIGIT_Y)),
        .digit(p2_score), .blank(blank_p2), .lit(hit_p2)
    );

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: behavioural game model feeds an expectation queue.
module tb_score_keeper;
    localparam int WIN   = 9;
    localparam int P1X   = 280;
    localparam int P2X   = 344;
    localparam int DY0   = 16;
    localparam int L     = 16;
    localparam int W     = 4;
    localparam int FLASH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = '0, y = '0;
    logic       de = 1'b0, frame = 1'b0, p1_point = 1'b0, p2_point = 1'b0, new_game = 1'b0;
    logic [3:0] p1_score, p2_score;
    logic [1:0] serve_side;
    logic       game_over, winner, pix_en;

    score_keeper #(
        .WIN_SCORE(WIN), .P1_DIGIT_X(P1X), .P2_DIGIT_X(P2X), .DIGIT_Y(DY0),
        .SEG_LEN(L), .SEG_W(W), .FLASH_FRAMES(FLASH)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .de(de), .frame(frame),
        .p1_point(p1_point), .p2_point(p2_point), .new_game(new_game),
        .p1_score(p1_score), .p2_score(p2_score), .serve_side(serve_side),
        .game_over(game_over), .winner(winner), .pix_en(pix_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p1, p2, serve, over, win, pix;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Game model state, kept as plain integers.
    int  m_p1, m_p2, m_serve, m_win, m_flash;
    bit  m_over, m_pend1, m_pend2, m_phase;

    function automatic string digit_segs(int d);
        case (d)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            default: return "";
        endcase
    endfunction

    function automatic bit digit_lit(int px, int py, int ox, int d, bit blank);
        int    dx = px - ox;
        int    dy = py - DY0;
        string s;
        if (blank || dx < 0 || dx >= L || dy < 0 || dy >= 2 * L) return 0;
        s = digit_segs(d);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "a": if (dy < W) return 1;
                "d": if (dy >= 2 * L - W) return 1;
                "g": if (dy >= L - W / 2 && dy < L + W / 2) return 1;
                "f": if (dx < W && dy < L) return 1;
                "b": if (dx >= L - W && dy < L) return 1;
                "e": if (dx < W && dy >= L) return 1;
                "c": if (dx >= L - W && dy >= L) return 1;
                default: ;
            endcase
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_serve = 1; m_win = 0; m_flash = 0;
        m_over = 0; m_pend1 = 0; m_pend2 = 0; m_phase = 1;
    endtask

    // One clock of the game rules; returns the pixel value due after this edge.
    task automatic model_step(input bit r, input bit d, input int px, input int py,
                              input bit fr, input bit a, input bit b, input bit ng,
                              output int pix);
        bit blank;
        if (r) begin
            model_reset();
            pix = 0;
            return;
        end
        blank = m_over && !m_phase;
        pix = d && (digit_lit(px, py, P1X, m_p1, blank && m_win == 0) ||
                    digit_lit(px, py, P2X, m_p2, blank && m_win == 1));
        if (!m_over) begin
            if (fr) begin
                if (m_pend1 && m_pend2) m_serve = 2;
                else if (m_pend1)       m_serve = 1;
                else if (m_pend2)       m_serve = 2;
                if (m_pend1 && m_p1 < WIN) m_p1++;
                if (m_pend2 && m_p2 < WIN) m_p2++;
                if (m_p1 == WIN)      begin m_over = 1; m_win = 0; end
                else if (m_p2 == WIN) begin m_over = 1; m_win = 1; end
                m_pend1 = m_over ? 1'b0 : a;
                m_pend2 = m_over ? 1'b0 : b;
            end else begin
                m_pend1 = m_pend1 | a;
                m_pend2 = m_pend2 | b;
            end
        end else begin
            m_pend1 = 0;
            m_pend2 = 0;
            if (fr) begin
                if (ng) begin
                    m_p1 = 0; m_p2 = 0; m_over = 0;
                    m_serve = (m_win == 0) ? 1 : 2;
                    m_flash = 0; m_phase = 1;
                end else begin
                    m_flash++;
                    if (m_flash == FLASH) begin
                        m_flash = 0;
                        m_phase = !m_phase;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic cyc(input bit r, input bit d, input int px, input int py,
                       input bit fr, input bit a, input bit b, input bit ng);
        exp_t e;
        int   pix;
        @(negedge clk);
        rst = r; de = d; x = 10'(px); y = 10'(py);
        frame = fr; p1_point = a; p2_point = b; new_game = ng;
        model_step(r, d, px, py, fr, a, b, ng, pix);
        e.p1 = m_p1; e.p2 = m_p2; e.serve = m_serve; e.over = int'(m_over);
        e.win = m_win; e.pix = pix;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 1'($urandom_range(0, 1)), 270 + int'($urandom_range(0, 99)),
                int'($urandom_range(0, 59)), 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor: every edge with a queued expectation is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("p1_score",   int'(p1_score),   e.p1);
                chk("p2_score",   int'(p2_score),   e.p2);
                chk("serve_side", int'(serve_side), e.serve);
                chk("game_over",  int'(game_over),  e.over);
                if (e.over != 0) chk("winner", int'(winner), e.win);
                chk("pix_en",     int'(pix_en),     e.pix);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Score 0: centre pixel (g segment) dark, top bar lit.
        cyc(0, 1, P1X + 8, DY0 + 16, 0, 0, 0, 0);
        cyc(0, 1, P1X, DY0, 0, 0, 0, 0);
        // Single p1 point, held off until the strobe.
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        // Three p2 pulses in one frame count once.
        repeat (3) begin cyc(0, 0, 0, 0, 0, 0, 1, 0); idle(1); end
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        // Pulse coincident with the strobe lands in the following frame.
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        // Bring both to 8 (p1 already 2, p2 1).
        repeat (6) begin cyc(0, 0, 0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0, 0, 0); end
        cyc(0, 0, 0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0, 0, 0);
        repeat (6) begin cyc(0, 0, 0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1, 0, 0, 0); end
        // p1 = 8: centre pixel lit with de, dark without; column left of box never lit.
        cyc(0, 1, P1X + 8, DY0 + 16, 0, 0, 0, 0);
        cyc(0, 0, P1X + 8, DY0 + 16, 0, 0, 0, 0);
        cyc(0, 1, P1X - 1, DY0 + 16, 0, 0, 0, 0);
        cyc(0, 1, P1X - 1, DY0, 0, 0, 0, 0);
        // Simultaneous winning points: p1 wins the tie.
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        // Points ignored in OVER; flash phases across 70 frames.
        repeat (3) begin cyc(0, 0, 0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0, 1, 0); end
        repeat (67) begin
            cyc(0, 0, 0, 0, 1, 0, 0, 0);
            cyc(0, 1, P1X + 8, DY0 + 16, 0, 0, 0, 0);
            cyc(0, 1, P2X + 8, DY0 + 16, 0, 0, 0, 0);
        end
        // Restart: loser p2 serves; new_game in PLAY does nothing.
        cyc(0, 0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0, 1);
        // p2 runs to victory, then restart serves toward p1.
        repeat (9) begin cyc(0, 0, 0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1, 0, 0, 1); end
        cyc(0, 1, P2X + 8, DY0 + 16, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 1);
        // Reset mid-frame on a lit pixel.
        cyc(0, 1, P1X, DY0, 0, 1, 0, 0);
        cyc(1, 1, P1X, DY0, 0, 0, 0, 0);
        cyc(0, 1, P1X, DY0, 1, 0, 0, 0);
        // Random play.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 499) == 0,
                1'($urandom_range(0, 1)),
                270 + int'($urandom_range(0, 99)),
                int'($urandom_range(0, 59)),
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
